mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
// Memory-stage load/store controller sitting between the pipeline MEM stage and data_mem.
// Accepts one MIPS load/store request at a time (LB/LBU/LH/LHU/LW/SB/SH/SW).
// Drives data_mem's byte/word port and splits halfword accesses into two big-endian byte accesses.
// Sign/zero-extends load data; flags misaligned, out-of-range and illegal requests without touching memory.
// PARAMETERS
// MEM_DEPTH  1000000  highest valid byte address of data_mem (matches its MEM_DEPTH)
// PORTS
// clock         in   1   rising-edge clock
// reset         in   1   synchronous, active-high reset
// req_valid     in   1   request present
// req_ready     out  1   controller idle; request accepted when req_valid && req_ready
// req_op        in   4   0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU, 8 SB, 9 SH, 10 SW; any other code is illegal
// req_addr      in   32  byte address
// req_wdata     in   32  store data (SB uses [7:0], SH uses [15:0], SW uses [31:0])
// resp_valid    out  1   one-cycle completion pulse (consumer never stalls)
// resp_rdata    out  32  extended load data; 0 for stores and errors
// resp_err      out  1   request was misaligned, out of range or illegal (valid with resp_valid)
// mem_addr      out  32  to data_mem w_addr_32
// mem_wdata     out  32  to data_mem w_data_in_32
// mem_write_op  out  1   to data_mem w_write_op
// mem_en        out  1   to data_mem w_en
// mem_byte_op   out  1   to data_mem w_byte_op
// mem_rdata_32  in   32  from data_mem w_data_out_32 (combinational read)
// mem_rdata_8   in   8   from data_mem w_data_out_8 (combinational read)
// BEHAVIOUR
// - FSM states: IDLE, ACC0, ACC1, DONE. req_ready = (state==IDLE).
// - Reset: state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, mem_en=0, mem_write_op=0,
//   mem_byte_op=0, mem_addr=0, mem_wdata=0. Requests presented while reset=1 are ignored.
// - IDLE: on accept, latch op/addr/wdata.
//   Error check: word with addr[1:0]!=0; half with addr[0]!=0; last byte touched > MEM_DEPTH; illegal op.
//   If any check fails -> DONE with err=1. Otherwise -> ACC0.
// - ACC0: mem_en=1, mem_addr=addr, mem_write_op=store.
//   mem_byte_op=0 for LW/SW, 1 otherwise.
//   mem_wdata: SW = wdata; SB = {24'b0,wdata[7:0]}; SH = {24'b0,wdata[15:8]}.
//   Read data is captured at the end of the cycle (mem_rdata_32 for LW, mem_rdata_8 otherwise).
//   Next state: ACC1 for LH/LHU/SH, DONE otherwise.
// - ACC1 (halfword only): mem_en=1, mem_byte_op=1, mem_addr=addr+1.
//   SH writes {24'b0,wdata[7:0]}; loads capture the low byte. Next state: DONE.
// - DONE: resp_valid=1 for exactly one cycle with rdata/err, then IDLE.
//   mem_en=0 in every state except ACC0/ACC1.
// - Load extension (big-endian):
//   LB -> {{24{b0[7]}},b0}; LBU -> {24'b0,b0}
//   LH -> {{16{b0[7]}},b0,b1}; LHU -> {16'b0,b0,b1}; LW -> the word as read.
// - Latency: request accepted at edge N. resp_valid is high in the cycle after edge
//   N+2 (byte/word), N+3 (halfword), or N+1 (error).
//   Back-to-back issue: next accept possible one cycle after resp_valid.
// - Errors never assert mem_en. The error response has resp_rdata=0.
// - Reset mid-operation: FSM returns to IDLE and mem_en drops on the following cycle.
//   No response is issued for the aborted request. A reset after the ACC0 write of an SH
//   leaves only the high byte written.
// - Address arithmetic is 32-bit. addr+1 never wraps past MEM_DEPTH because of the range check.
// TESTING
// - SW 0xDEADBEEF @0x100, then LW @0x100 -> resp_rdata=0xDEADBEEF, err=0; resp 2 cycles after each accept.
// - LB @0x100 -> 0xFFFFFFDE; LBU @0x103 -> 0x000000EF; SB 0x55 @0x101 then LW @0x100 -> 0xDE55BEEF.
// - SH 0x8001 @0x202 -> two byte writes (0x80 @0x202, 0x01 @0x203); LH -> 0xFFFF8001; LHU -> 0x00008001; 3-cycle latency.
// - LW @0x101, SH @0x203, LW @MEM_DEPTH-2, op=3 -> resp_err=1, resp_rdata=0, mem_en never asserted, resp 1 cycle after accept.
// - Reset asserted during ACC1 of SH 0xABCD @0x300 -> no resp_valid; req_ready=1 after reset; LHU @0x300 -> 0x0000AB<old byte>.
// - req_valid held high continuously with 4 LW requests -> exactly 4 accepts, each req_ready low until its resp_valid has passed.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake between the MEM stage and the load/store controller.
// The pipeline side drives requests (master); the controller answers (slave).
interface mem_access_ctrl_if;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned DATA_W = 32;

  logic              req_valid;
  logic              req_ready;
  logic [OP_W-1:0]   req_op;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller in front of data_mem: one request at a time,
// halfwords split into two big-endian byte accesses, loads sign/zero-extended.
module mem_access_ctrl #(
  parameter int unsigned MEM_DEPTH = 32'd1000000
) (
  input  logic               clock,
  input  logic               reset,
  mem_access_ctrl_if.slave   bus,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_wdata,
  output logic               mem_write_op,
  output logic               mem_en,
  output logic               mem_byte_op,
  input  logic [31:0]        mem_rdata_32,
  input  logic [7:0]         mem_rdata_8
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [7:0]          b0_q, b0_d;
  logic                hi_q, hi_d;
  logic                ready_q, ready_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_write_op_q, mem_write_op_d;
  logic                mem_byte_op_q, mem_byte_op_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;

  logic                req_legal_c, req_misal_c, req_bad_c;
  logic [ADDR_W:0]     req_last_c;
  logic                op_store_c, op_half_c, op_word_c;
  logic [7:0]          ext_byte_c;
  logic [15:0]         ext_half_c;
  logic [DATA_W-1:0]   load_ext_c;

  // Validate the incoming request: opcode, alignment and last byte touched.
  always_comb begin
    req_legal_c = 1'b0;
    req_misal_c = 1'b0;
    req_last_c  = {1'b0, bus.req_addr};
    case (bus.req_op)
      4'd0, 4'd4, 4'd8: req_legal_c = 1'b1;
      4'd1, 4'd5, 4'd9: begin
        req_legal_c = 1'b1;
        req_misal_c = bus.req_addr[0];
        req_last_c  = {1'b0, bus.req_addr} + 33'd1;
      end
      4'd2, 4'd10: begin
        req_legal_c = 1'b1;
        req_misal_c = (bus.req_addr[1:0] != 2'b00);
        req_last_c  = {1'b0, bus.req_addr} + 33'd3;
      end
      default: req_legal_c = 1'b0;
    endcase
    req_bad_c = !req_legal_c || req_misal_c || (req_last_c > 33'(MEM_DEPTH));
  end

  assign op_store_c = op_q[3];
  assign op_half_c  = (op_q[1:0] == 2'd1);
  assign op_word_c  = (op_q[1:0] == 2'd2);

  // Memory outputs lag the state by one register, so read data is live during DONE.
  always_comb begin
    ext_byte_c = mem_rdata_8;
    ext_half_c = {b0_q, mem_rdata_8};
    if (op_word_c) begin
      load_ext_c = mem_rdata_32;
    end else if (op_half_c) begin
      load_ext_c = op_q[2] ? {16'h0000, ext_half_c} : {{16{ext_half_c[15]}}, ext_half_c};
    end else begin
      load_ext_c = op_q[2] ? {24'h000000, ext_byte_c} : {{24{ext_byte_c[7]}}, ext_byte_c};
    end
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    err_d          = err_q;
    b0_d           = b0_q;
    hi_d           = 1'b0;
    mem_en_d       = 1'b0;
    mem_write_op_d = 1'b0;
    mem_byte_op_d  = 1'b0;
    mem_addr_d     = '0;
    mem_wdata_d    = '0;
    resp_valid_d   = 1'b0;
    resp_err_d     = 1'b0;
    resp_rdata_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          err_d   = req_bad_c;
          state_d = req_bad_c ? S_DONE : S_ACC0;
        end
      end
      S_ACC0: begin
        mem_en_d       = 1'b1;
        mem_addr_d     = addr_q;
        mem_write_op_d = op_store_c;
        mem_byte_op_d  = !op_word_c;
        if (op_store_c) begin
          if (op_word_c)      mem_wdata_d = wdata_q;
          else if (op_half_c) mem_wdata_d = {24'h000000, wdata_q[15:8]};
          else                mem_wdata_d = {24'h000000, wdata_q[7:0]};
        end
        state_d = op_half_c ? S_ACC1 : S_DONE;
      end
      S_ACC1: begin
        mem_en_d       = 1'b1;
        mem_addr_d     = addr_q + 32'd1;
        mem_write_op_d = op_store_c;
        mem_byte_op_d  = 1'b1;
        mem_wdata_d    = op_store_c ? {24'h000000, wdata_q[7:0]} : '0;
        hi_d           = 1'b1;
        state_d        = S_DONE;
      end
      S_DONE: begin
        resp_valid_d = 1'b1;
        resp_err_d   = err_q;
        resp_rdata_d = (err_q || op_store_c) ? '0 : load_ext_c;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    if (mem_en_q && !hi_q) b0_d = mem_rdata_8;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      op_q           <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      err_q          <= 1'b0;
      b0_q           <= '0;
      hi_q           <= 1'b0;
      ready_q        <= 1'b1;
      mem_en_q       <= 1'b0;
      mem_write_op_q <= 1'b0;
      mem_byte_op_q  <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      resp_valid_q   <= 1'b0;
      resp_err_q     <= 1'b0;
      resp_rdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      err_q          <= err_d;
      b0_q           <= b0_d;
      hi_q           <= hi_d;
      ready_q        <= ready_d;
      mem_en_q       <= mem_en_d;
      mem_write_op_q <= mem_write_op_d;
      mem_byte_op_q  <= mem_byte_op_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      resp_valid_q   <= resp_valid_d;
      resp_err_q     <= resp_err_d;
      resp_rdata_q   <= resp_rdata_d;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign mem_en         = mem_en_q;
  assign mem_write_op   = mem_write_op_q;
  assign mem_byte_op    = mem_byte_op_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: byte-array data_mem, transaction-level reference model
// checked every cycle, plus directed requests with hand-computed results.
module tb_mem_access_ctrl;
  localparam int unsigned MEM_DEPTH = 1000000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata_32;
  logic        mem_write_op, mem_en, mem_byte_op;
  logic [7:0]  mem_rdata_8;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_write_op (mem_write_op),
    .mem_en       (mem_en),
    .mem_byte_op  (mem_byte_op),
    .mem_rdata_32 (mem_rdata_32),
    .mem_rdata_8  (mem_rdata_8)
  );

  always #5 clock = ~clock;

  // data_mem stand-in: 1 KiB aliased, big-endian words, combinational read.
  logic [7:0] dmem [0:1023] = '{default: 8'h00};
  always @(posedge clock) begin
    if (mem_en && mem_write_op) begin
      if (mem_byte_op) dmem[mem_addr[9:0]] <= mem_wdata[7:0];
      else for (int j = 0; j < 4; j++) dmem[mem_addr[9:0] + 10'(j)] <= mem_wdata[8*(3-j) +: 8];
    end
  end
  always_comb begin
    mem_rdata_8  = dmem[mem_addr[9:0]];
    mem_rdata_32 = {dmem[mem_addr[9:0]], dmem[mem_addr[9:0] + 10'd1],
                    dmem[mem_addr[9:0] + 10'd2], dmem[mem_addr[9:0] + 10'd3]};
  end

  logic [7:0]  ref_mem [0:1023] = '{default: 8'h00};
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          p_valid = 1'b0;
  bit          p_err;
  int          p_acc, p_lat, p_nacc, p_size;
  logic [3:0]  p_op;
  logic [31:0] p_addr, p_wdata, p_rdata;
  logic [7:0]  p_old [4];
  bit          last_acc, last_rv, last_err;
  logic [31:0] last_rdata;
  int          last_lat;

  function automatic int op_size(logic [3:0] op);
    case (op)
      4'd0, 4'd4, 4'd8:  return 1;
      4'd1, 4'd5, 4'd9:  return 2;
      4'd2, 4'd10:       return 4;
      default:           return 0;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Transaction model: decide error, latency and result; stores land in ref_mem.
  task automatic model_accept(logic [3:0] op, logic [31:0] a, logic [31:0] wd);
    logic [31:0] v;
    p_valid = 1'b1; p_acc = cyc; p_op = op; p_addr = a; p_wdata = wd;
    p_size  = op_size(op);
    p_err   = (p_size == 0);
    if (!p_err) p_err = ((a % p_size) != 0) || (longint'(a) + p_size - 1 > longint'(MEM_DEPTH));
    p_lat   = p_err ? 1 : ((p_size == 2) ? 3 : 2);
    p_nacc  = (p_size == 2) ? 2 : 1;
    p_rdata = '0;
    if (!p_err) begin
      if (op[3]) begin
        for (int j = 0; j < p_size; j++) begin
          p_old[j] = ref_mem[10'(a + 32'(j))];
          ref_mem[10'(a + 32'(j))] = wd[8*(p_size-1-j) +: 8];
        end
      end else begin
        v = '0;
        for (int j = 0; j < p_size; j++) v = (v << 8) | {24'h0, ref_mem[10'(a + 32'(j))]};
        if (!op[2] && p_size == 1 && v[7])  v = v | 32'hFFFFFF00;
        if (!op[2] && p_size == 2 && v[15]) v = v | 32'hFFFF0000;
        p_rdata = v;
      end
    end
  endtask

  // Reset at edge cyc: byte writes scheduled after this edge never happen.
  task automatic abort_pending();
    int we;
    if (p_valid && !p_err && p_op[3]) begin
      for (int j = 0; j < p_size; j++) begin
        we = p_acc + 2 + ((p_size == 2) ? j : 0);
        if (we > cyc) ref_mem[10'(p_addr + 32'(j))] = p_old[j];
      end
    end
    p_valid = 1'b0;
  endtask

  task automatic compare();
    int due, k;
    bit exp_rv, exp_en, exp_ready;
    due       = p_acc + p_lat;
    exp_rv    = p_valid && (cyc == due);
    exp_ready = !(p_valid && cyc < due);
    exp_en    = p_valid && !p_err && (cyc > p_acc) && (cyc <= p_acc + p_nacc);
    chk("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    chk("mem_en", 32'(mem_en), 32'(exp_en));
    last_rv = bus.resp_valid; last_rdata = bus.resp_rdata; last_err = bus.resp_err;
    last_lat = cyc - p_acc;
    if (exp_rv) begin
      chk("model resp_rdata", bus.resp_rdata, p_rdata);
      chk("model resp_err", 32'(bus.resp_err), 32'(p_err));
      p_valid = 1'b0;
    end
    if (exp_en) begin
      k = cyc - p_acc - 1;
      chk("mem_addr", mem_addr, p_addr + 32'(k));
      chk("mem_write_op", 32'(mem_write_op), 32'(p_op[3]));
      chk("mem_byte_op", 32'(mem_byte_op), 32'(p_size != 4));
      if (p_op[3])
        chk("mem_wdata", mem_wdata, (p_size == 4) ? p_wdata : {24'h0, p_wdata[8*(p_size-1-k) +: 8]});
    end
  endtask

  // One clock: record a handshake at the edge, then check outputs mid-cycle.
  task automatic tick();
    bit acc, rst;
    logic [3:0] op;
    logic [31:0] a, wd;
    acc = bus.req_valid && bus.req_ready && !reset;
    rst = reset;
    op = bus.req_op; a = bus.req_addr; wd = bus.req_wdata;
    @(posedge clock);
    cyc++;
    last_acc = 1'b0;
    if (rst) abort_pending();
    else if (acc) begin
      model_accept(op, a, wd);
      last_acc = 1'b1;
    end
    @(negedge clock);
    compare();
  endtask

  task automatic do_req(string nm, logic [3:0] op, logic [31:0] a, logic [31:0] wd,
                        logic [31:0] exp_rd, bit exp_err, int exp_lat);
    int n;
    bit got;
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = a; bus.req_wdata = wd;
    tick();
    bus.req_valid = 1'b0;
    chk({nm, " accept"}, 32'(last_acc), 32'd1);
    n = 0; got = 1'b0;
    while (!got && n < 8) begin
      tick();
      n++;
      got = last_rv;
    end
    chk({nm, " resp_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({nm, " rdata"}, last_rdata, exp_rd);
      chk({nm, " err"}, 32'(last_err), 32'(exp_err));
      chk({nm, " latency"}, 32'(last_lat), 32'(exp_lat));
    end
  endtask

  initial begin
    logic [31:0] ba [4];
    logic [31:0] be [4];
    int na, nr, prev, n;

    // Requests offered while reset is high must be ignored.
    bus.req_valid = 1'b1; bus.req_op = 4'd2; bus.req_addr = 32'h100; bus.req_wdata = '0;
    reset = 1'b1;
    repeat (3) tick();
    chk("rst resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst mem_write_op", 32'(mem_write_op), 32'd0);
    bus.req_valid = 1'b0;
    reset = 1'b0;
    tick();

    do_req("SW",        4'd10, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 2);
    do_req("LW",        4'd2,  32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 2);
    do_req("LB",        4'd0,  32'h100, 32'h0,        32'hFFFFFFDE, 1'b0, 2);
    do_req("LBU",       4'd4,  32'h103, 32'h0,        32'h000000EF, 1'b0, 2);
    do_req("SB",        4'd8,  32'h101, 32'h12345655, 32'h0,        1'b0, 2);
    do_req("LW after SB", 4'd2, 32'h100, 32'h0,       32'hDE55BEEF, 1'b0, 2);
    do_req("SH",        4'd9,  32'h202, 32'hFFFF8001, 32'h0,        1'b0, 3);
    do_req("LH",        4'd1,  32'h202, 32'h0,        32'hFFFF8001, 1'b0, 3);
    do_req("LHU",       4'd5,  32'h202, 32'h0,        32'h00008001, 1'b0, 3);
    do_req("LB lo",     4'd0,  32'h203, 32'h0,        32'h00000001, 1'b0, 2);

    do_req("LW misal",  4'd2,  32'h101, 32'h0, 32'h0, 1'b1, 1);
    do_req("SH misal",  4'd9,  32'h203, 32'h1234, 32'h0, 1'b1, 1);
    do_req("LW range",  4'd2,  32'(MEM_DEPTH - 2), 32'h0, 32'h0, 1'b1, 1);
    do_req("op3",       4'd3,  32'h0, 32'h0, 32'h0, 1'b1, 1);
    do_req("op15",      4'd15, 32'h0, 32'h0, 32'h0, 1'b1, 1);
    do_req("LH top",    4'd1,  32'(MEM_DEPTH), 32'h0, 32'h0, 1'b1, 1);
    do_req("LB wrap",   4'd0,  32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 1);
    do_req("LB top",    4'd0,  32'(MEM_DEPTH), 32'h0, 32'h0, 1'b0, 2);
    do_req("LW top",    4'd2,  32'(MEM_DEPTH - 4), 32'h0, 32'h0, 1'b0, 2);

    // Reset lands while the SH is in its second half: only 0xAB reaches memory.
    do_req("SW pre",    4'd10, 32'h300, 32'h11223344, 32'h0, 1'b0, 2);
    bus.req_valid = 1'b1; bus.req_op = 4'd9; bus.req_addr = 32'h300; bus.req_wdata = 32'h0000ABCD;
    tick();
    bus.req_valid = 1'b0;
    chk("SH abort accept", 32'(last_acc), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ready after reset", 32'(bus.req_ready), 32'd1);
    repeat (4) tick();
    do_req("LHU abort", 4'd5, 32'h300, 32'h0, 32'h0000AB22, 1'b0, 3);

    // Back-to-back: req_valid held high across four LW requests.
    ba = '{32'h100, 32'h200, 32'h300, 32'h104};
    be = '{32'hDE55BEEF, 32'h00008001, 32'hAB223344, 32'h00000000};
    na = 0; nr = 0; prev = 0; n = 0;
    bus.req_valid = 1'b1; bus.req_op = 4'd2; bus.req_addr = ba[0]; bus.req_wdata = '0;
    while ((na < 4 || nr < 4) && n < 60) begin
      tick();
      n++;
      if (last_acc) begin
        if (na > 0) chk("b2b accept gap", 32'(cyc - prev), 32'd3);
        prev = cyc;
        na++;
        if (na < 4) bus.req_addr = ba[na];
        else        bus.req_valid = 1'b0;
      end
      if (last_rv) begin
        if (nr < 4) chk("b2b rdata", last_rdata, be[nr]);
        nr++;
      end
    end
    chk("b2b accepts", 32'(na), 32'd4);
    chk("b2b responses", 32'(nr), 32'd4);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
